// File: rtl/ram_nr1w_sync_clear.sv
// Multi-read, single-write RAM with registered reads, byte-enable writes,
// write-first forwarding and a hardware clear sweep after reset or on request.
module ram_nr1w_sync_clear #(
    parameter int unsigned          DataWidth        = 32,
    parameter int unsigned          NumEntries       = 16,
    parameter int unsigned          NumReadPorts     = 2,
    parameter bit                   ClearOnReset     = 1'b1,
    parameter logic [DataWidth-1:0] ClearValue       = '0,
    parameter string                ReadmemhFilename = "memory_init_file.memh",
    localparam int unsigned         AddrWidth        = (NumEntries > 1) ? $clog2(NumEntries) : 1,
    localparam int unsigned         NumBytes         = DataWidth / 8
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              init_i,
    output logic                              busy_o,
    input  logic                              wr_valid_i,
    input  logic [AddrWidth-1:0]              wr_addr_i,
    input  logic [DataWidth-1:0]              wr_data_i,
    input  logic [NumBytes-1:0]               wr_be_i,
    input  logic [NumReadPorts-1:0]           rd_valid_i,
    input  logic [NumReadPorts*AddrWidth-1:0] rd_addr_i,
    output logic [NumReadPorts-1:0]           rd_valid_o,
    output logic [NumReadPorts*DataWidth-1:0] rd_data_o
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic [AddrWidth:0]   Depth      = (AddrWidth + 1)'(NumEntries);
    localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(NumEntries - 1);
    localparam state_e               ResetState = ClearOnReset ? StClear : StIdle;
    // Preloading from the file is left to the simulation environment.
    localparam bit unused_init_file = (ReadmemhFilename == "");

    state_e                            state_q, state_d;
    logic [AddrWidth-1:0]              cnt_q, cnt_d;
    logic [DataWidth-1:0]              mem_q [NumEntries];
    logic                              idle;
    logic                              wr_in_range;
    logic                              wr_en;
    logic [DataWidth-1:0]              wr_word;
    logic [AddrWidth-1:0]              rd_addr;
    logic [NumReadPorts-1:0]           rd_accept;
    logic [NumReadPorts-1:0]           rd_valid_q;
    logic [NumReadPorts*DataWidth-1:0] rd_data_q, rd_data_d;

    assign idle        = (state_q == StIdle);
    assign busy_o      = (state_q == StClear);
    assign wr_in_range = ({1'b0, wr_addr_i} < Depth);
    assign wr_en       = idle && wr_valid_i && !init_i && wr_in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (init_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Post-write word: enabled bytes from the write data, the rest from old contents.
    always_comb begin
        wr_word = wr_in_range ? mem_q[wr_addr_i] : '0;
        for (int b = 0; b < NumBytes; b++) begin
            if (wr_be_i[b]) begin
                wr_word[8*b +: 8] = wr_data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            mem_q[cnt_q] <= ClearValue;
        end else if (wr_en) begin
            mem_q[wr_addr_i] <= wr_word;
        end
    end

    always_comb begin
        rd_addr   = '0;
        rd_accept = '0;
        rd_data_d = rd_data_q;
        for (int p = 0; p < NumReadPorts; p++) begin
            rd_addr      = rd_addr_i[p*AddrWidth +: AddrWidth];
            rd_accept[p] = rd_valid_i[p] && idle;
            if (rd_accept[p]) begin
                if ({1'b0, rd_addr} >= Depth) begin
                    rd_data_d[p*DataWidth +: DataWidth] = '0;
                end else if (wr_en && (wr_addr_i == rd_addr)) begin
                    rd_data_d[p*DataWidth +: DataWidth] = wr_word;
                end else begin
                    rd_data_d[p*DataWidth +: DataWidth] = mem_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ResetState;
            cnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_accept;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_ram_nr1w_sync_clear.sv
// Directed bench for ram_nr1w_sync_clear: a 16-entry instance and a 12-entry
// instance, with read expectations queued at issue and compared one cycle later.
module tb_ram_nr1w_sync_clear;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        init_a, busy_a, wr_valid_a;
    logic [3:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic [3:0]  wr_be_a;
    logic [1:0]  rd_valid_a, rd_valid_o_a;
    logic [7:0]  rd_addr_a;
    logic [63:0] rd_data_o_a;

    logic        init_b, busy_b, wr_valid_b;
    logic [3:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [3:0]  wr_be_b;
    logic [1:0]  rd_valid_b, rd_valid_o_b;
    logic [7:0]  rd_addr_b;
    logic [63:0] rd_data_o_b;

    ram_nr1w_sync_clear #(
        .DataWidth(32), .NumEntries(16), .NumReadPorts(2), .ClearOnReset(1'b1),
        .ClearValue(32'hDEAD_BEEF), .ReadmemhFilename("memory_init_file.memh")
    ) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .init_i(init_a), .busy_o(busy_a),
        .wr_valid_i(wr_valid_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a),
        .wr_be_i(wr_be_a), .rd_valid_i(rd_valid_a), .rd_addr_i(rd_addr_a),
        .rd_valid_o(rd_valid_o_a), .rd_data_o(rd_data_o_a)
    );

    ram_nr1w_sync_clear #(
        .DataWidth(32), .NumEntries(12), .NumReadPorts(2), .ClearOnReset(1'b1),
        .ClearValue(32'h0), .ReadmemhFilename("memory_init_file.memh")
    ) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .init_i(init_b), .busy_o(busy_b),
        .wr_valid_i(wr_valid_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
        .wr_be_i(wr_be_b), .rd_valid_i(rd_valid_b), .rd_addr_i(rd_addr_b),
        .rd_valid_o(rd_valid_o_b), .rd_data_o(rd_data_o_b)
    );

    typedef struct {
        string       tag;
        bit          is_b;
        int          port;
        logic        v;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input bit is_b, input int port,
                             input logic v, input logic [31:0] d);
        exp_t e;
        e.tag  = tag;
        e.is_b = is_b;
        e.port = port;
        e.v    = v;
        e.d    = d;
        sb.push_back(e);
    endtask

    // Advance one clock, then compare every queued read expectation.
    task automatic step();
        exp_t        e;
        logic        ov;
        logic [31:0] od;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ov = e.is_b ? rd_valid_o_b[e.port] : rd_valid_o_a[e.port];
            od = e.is_b ? rd_data_o_b[e.port*32 +: 32] : rd_data_o_a[e.port*32 +: 32];
            check({e.tag, ".valid"}, {31'b0, ov}, {31'b0, e.v});
            check({e.tag, ".data"}, od, e.d);
        end
    endtask

    task automatic idle_a();
        init_a = 1'b0; wr_valid_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; wr_be_a = '0;
        rd_valid_a = '0; rd_addr_a = '0;
    endtask

    task automatic idle_b();
        init_b = 1'b0; wr_valid_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; wr_be_b = '0;
        rd_valid_b = '0; rd_addr_b = '0;
    endtask

    task automatic count_busy_a(output int n);
        n = 0;
        while (busy_a && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_a();
        idle_b();
        reset_n = 1'b0;
        #12;
        check("reset_busy", {31'b0, busy_a}, 32'd1);
        check("reset_rd_valid", {30'b0, rd_valid_o_a}, 32'd0);
        check("reset_rd_data_lo", rd_data_o_a[31:0], 32'd0);
        check("reset_rd_data_hi", rd_data_o_a[63:32], 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        count_busy_a(n);
        check("reset_sweep_len", n, 32'd16);

        for (int a = 0; a < 16; a += 2) begin
            rd_valid_a = 2'b11;
            rd_addr_a  = {4'(a + 1), 4'(a)};
            expect_rd($sformatf("rd_all_%0d", a), 1'b0, 0, 1'b1, 32'hDEAD_BEEF);
            expect_rd($sformatf("rd_all_%0d", a + 1), 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
            step();
        end

        idle_a();
        expect_rd("no_req_p0", 1'b0, 0, 1'b0, 32'hDEAD_BEEF);
        expect_rd("no_req_p1", 1'b0, 1, 1'b0, 32'hDEAD_BEEF);
        step();

        wr_valid_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 32'h1122_3344; wr_be_a = 4'hF;
        step();
        wr_data_a = 32'hAAAA_AAAA; wr_be_a = 4'b0101;
        step();
        // Zero byte enables: no-op, and the forwarded word is the old contents.
        wr_data_a = 32'h0; wr_be_a = 4'h0;
        rd_valid_a = 2'b01; rd_addr_a = {4'd0, 4'd3};
        expect_rd("be_merge", 1'b0, 0, 1'b1, 32'h11AA_33AA);
        expect_rd("be_merge_hold_p1", 1'b0, 1, 1'b0, 32'hDEAD_BEEF);
        step();
        idle_a();
        rd_valid_a = 2'b10; rd_addr_a = {4'd3, 4'd0};
        expect_rd("be_zero_noop", 1'b0, 1, 1'b1, 32'h11AA_33AA);
        step();

        idle_a();
        wr_valid_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 32'h1234_5678; wr_be_a = 4'hF;
        step();
        wr_data_a = 32'h0000_00FF; wr_be_a = 4'h1;
        rd_valid_a = 2'b11; rd_addr_a = {4'd5, 4'd5};
        expect_rd("fwd_p0", 1'b0, 0, 1'b1, 32'h1234_56FF);
        expect_rd("fwd_p1", 1'b0, 1, 1'b1, 32'h1234_56FF);
        step();
        idle_a();
        rd_valid_a = 2'b01; rd_addr_a = {4'd0, 4'd5};
        expect_rd("fwd_stored", 1'b0, 0, 1'b1, 32'h1234_56FF);
        step();

        idle_a();
        init_a = 1'b1;
        wr_valid_a = 1'b1; wr_addr_a = 4'd2; wr_data_a = 32'h5555_5555; wr_be_a = 4'hF;
        rd_valid_a = 2'b01; rd_addr_a = {4'd0, 4'd3};
        expect_rd("init_cycle_read", 1'b0, 0, 1'b1, 32'h11AA_33AA);
        expect_rd("init_cycle_hold_p1", 1'b0, 1, 1'b0, 32'h1234_56FF);
        step();
        check("init_busy", {31'b0, busy_a}, 32'd1);

        idle_a();
        n = 0;
        while (busy_a && n < 100) begin
            idle_a();
            rd_valid_a = 2'b11; rd_addr_a = {4'd2, 4'd2};
            init_a = (n == 3);
            if (n == 5) begin
                wr_valid_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 32'h7777_7777; wr_be_a = 4'hF;
            end
            expect_rd($sformatf("sweep_rd_p0_%0d", n), 1'b0, 0, 1'b0, 32'h11AA_33AA);
            expect_rd($sformatf("sweep_rd_p1_%0d", n), 1'b0, 1, 1'b0, 32'h1234_56FF);
            step();
            n++;
        end
        check("init_sweep_len", n, 32'd16);

        idle_a();
        rd_valid_a = 2'b11; rd_addr_a = {4'd7, 4'd2};
        expect_rd("post_sweep_addr2", 1'b0, 0, 1'b1, 32'hDEAD_BEEF);
        expect_rd("post_sweep_addr7", 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
        step();

        idle_a();
        init_a = 1'b1;
        step();
        idle_a();
        repeat (7) step();
        reset_n = 1'b0;
        #2;
        check("midreset_busy", {31'b0, busy_a}, 32'd1);
        check("midreset_rd_valid", {30'b0, rd_valid_o_a}, 32'd0);
        check("midreset_rd_data_lo", rd_data_o_a[31:0], 32'd0);
        check("midreset_rd_data_hi", rd_data_o_a[63:32], 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_busy_a(n);
        check("midreset_sweep_len", n, 32'd16);

        check("b_idle", {31'b0, busy_b}, 32'd0);
        wr_valid_b = 1'b1; wr_addr_b = 4'd1; wr_data_b = 32'hCAFE_F00D; wr_be_b = 4'hF;
        step();
        wr_addr_b = 4'd13; wr_data_b = 32'hFFFF_FFFF;
        step();
        idle_b();
        rd_valid_b = 2'b11; rd_addr_b = {4'd1, 4'd13};
        expect_rd("oor_read", 1'b1, 0, 1'b1, 32'h0);
        expect_rd("oor_addr1_intact", 1'b1, 1, 1'b1, 32'hCAFE_F00D);
        step();
        wr_valid_b = 1'b1; wr_addr_b = 4'd13; wr_data_b = 32'hFFFF_FFFF; wr_be_b = 4'hF;
        rd_valid_b = 2'b11; rd_addr_b = {4'd11, 4'd13};
        expect_rd("oor_fwd", 1'b1, 0, 1'b1, 32'h0);
        expect_rd("b_last_entry", 1'b1, 1, 1'b1, 32'h0);
        step();
        idle_b();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_nr1w_sync_clear.md
Name: ram_nr1w_sync_clear

Overview:
Parametrised multi-read-port, single-write-port RAM with registered (1-cycle) reads, byte-enable writes and write-first forwarding.
Contains a hardware clear sequencer that sweeps every entry to a fixed value after reset or on request.
Serves as the general-purpose storage block for register files, tag/data arrays and lookup tables that need more than one read per cycle and a known post-reset state.

Parameters:
DataWidth, 32, word width in bits; must be a multiple of 8.
NumEntries, 16, number of words; need not be a power of two; minimum 2.
NumReadPorts, 2, number of independent read ports; minimum 1.
ClearOnReset, 1, 1 = run clear sweep after reset release; 0 = contents come from ReadmemhFilename and no sweep occurs.
ClearValue, 0, DataWidth-bit value written to each entry by a sweep.
ReadmemhFilename, "memory_init_file.memh", initial contents file; used only when ClearOnReset = 0.
Derived: AddrWidth = max(1, $clog2(NumEntries)); NumBytes = DataWidth/8.

Ports:
clk_i  input  1  clock, all state on rising edge.
reset_ni  input  1  asynchronous active-low reset.
init_i  input  1  one-cycle request to start a clear sweep.
busy_o  output  1  high while a sweep is in progress.
wr_valid_i  input  1  write request.
wr_addr_i  input  AddrWidth  write address.
wr_data_i  input  DataWidth  write data.
wr_be_i  input  NumBytes  byte enables; bit b covers bits [8b+7:8b].
rd_valid_i  input  NumReadPorts  per-port read request.
rd_addr_i  input  NumReadPorts*AddrWidth  packed read addresses; port p at [p*AddrWidth +: AddrWidth].
rd_valid_o  output  NumReadPorts  per-port read-data-valid, 1 cycle after request.
rd_data_o  output  NumReadPorts*DataWidth  packed registered read data; port p at [p*DataWidth +: DataWidth].

Behaviour:
- Reset (reset_ni low, asynchronous):
  - rd_valid_o = 0; rd_data_o = 0; sweep counter = 0.
  - State = CLEAR if ClearOnReset, else IDLE.
  - busy_o = ClearOnReset.
  - Array contents are not reset by the reset itself.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes ClearValue to entry[counter], then counter += 1.
  - After writing entry NumEntries-1, the next state is IDLE, counter returns to 0 and busy_o drops.
  - A sweep takes exactly NumEntries cycles.
  - IDLE with init_i = 1: next state CLEAR, busy_o = 1 from the next cycle.
  - init_i in CLEAR is ignored; the sweep does not restart.
  - If reset asserts mid-sweep, the sweep aborts immediately. After release it restarts from entry 0 if ClearOnReset; otherwise state is IDLE with partially cleared contents.
- Writes: accepted only in IDLE with wr_valid_i = 1 and init_i = 0.
  - Only bytes with wr_be_i[b] = 1 are updated; wr_be_i = 0 is a no-op.
  - Writes during CLEAR, or in the cycle init_i is asserted, are dropped silently.
- Reads: port p is accepted when rd_valid_i[p] = 1 and state is IDLE (busy_o = 0).
  - Next cycle: rd_valid_o[p] = 1 and rd_data_o[p] = entry contents.
  - Without an accepted request: rd_valid_o[p] = 0 and rd_data_o[p] holds its previous value.
- Write-first forwarding: if a read and an accepted write target the same address in the same cycle, the read returns the post-write word, i.e. enabled bytes from wr_data_i and the rest from old contents. This applies on every port independently.
- Read in the cycle init_i is asserted (state IDLE): accepted and returns pre-sweep contents.
- Reads in the same cycle to the same address from several ports: all return identical data.
- Address >= NumEntries (non-power-of-two depth):
  - write dropped.
  - read accepted with rd_valid_o = 1 and rd_data_o = 0.
- Simulation only: print NumEntries, DataWidth and NumReadPorts at elaboration; dump array entries.

Test Plan:
- Reset with ClearOnReset = 1, NumEntries = 16, ClearValue = 32'hDEAD_BEEF -> busy_o high for exactly 16 cycles after release; then a read of every address returns 32'hDEAD_BEEF and rd_valid_o is asserted 1 cycle after each request.
- IDLE: write addr 3 = 32'h1122_3344 with be 4'hF, then addr 3 data 32'hAAAA_AAAA with be 4'b0101 -> read addr 3 returns 32'h11AA_33AA.
- Same cycle: write addr 5 = 32'h0000_00FF (be 4'h1, old contents 32'h1234_5678) while port 0 and port 1 both read addr 5 -> both ports return 32'h1234_56FF next cycle.
- Pulse init_i in IDLE while writing addr 2 -> write dropped; busy_o = 1 for NumEntries cycles; reads issued during the sweep give rd_valid_o = 0 and rd_data_o unchanged; afterwards addr 2 reads ClearValue.
- Assert reset_ni low at sweep cycle 7, then release -> outputs return to 0 asynchronously; the sweep restarts at entry 0 and busy_o stays high for a full 16 cycles.
- NumEntries = 12: write addr 13 = 32'hFFFF_FFFF, then read addr 13 and addr 1 -> addr 13 returns 0 with rd_valid_o = 1; addr 1 is unchanged.
